// File: rtl/mac_result_quantizer_if.sv
// Byte-stream input and int8 valid/ready output of mac_result_quantizer.
// master = environment (producer of bytes, consumer of results); slave = quantizer.
interface mac_result_quantizer_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_first;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_byte, in_valid, in_first, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_byte, in_valid, in_first, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mac_result_quantizer.sv
// Collects a byte-serial 32-bit MAC result, requantizes it to int8 (shift, ReLU, saturate)
// and buffers results in a small FIFO. Define MACQ_ROUND_EN for round-half-up shifting.
module mac_result_quantizer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   mac_result_quantizer_if.slave        bus,
   input  logic [4:0]                   cfg_shift,
   input  logic                         cfg_relu,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         sat_flag,
   output logic                         frame_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {COLLECT, QUANT, PUSH} state_t;

   state_t      state;
   logic [1:0]  byte_cnt;
   logic [31:0] word;
   logic [4:0]  sh_q;
   logic        relu_q;
   logic [7:0]  q_value;

   logic signed [32:0] w_ext;
   logic signed [32:0] biased;
   logic signed [32:0] shifted;
   logic signed [32:0] relu_v;
   logic [7:0]         sat_value;
   logic               clip;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          push;
   logic          pop;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_ext = {word[31], word};
`ifdef MACQ_ROUND_EN
      biased = (sh_q == 5'd0) ? w_ext : w_ext + (33'sd1 <<< (sh_q - 5'd1));
`else
      biased = w_ext;
`endif
      shifted = biased >>> sh_q;
      relu_v  = (relu_q && shifted < 33'sd0) ? 33'sd0 : shifted;
      clip      = 1'b0;
      sat_value = relu_v[7:0];
      if (relu_v > 33'sd127) begin
         sat_value = 8'h7F;
         clip      = 1'b1;
      end else if (relu_v < -33'sd128) begin
         sat_value = 8'h80;
         clip      = 1'b1;
      end
   end

   assign full          = (fifo_count == FULL_CNT);
   assign bus.out_valid = (fifo_count != '0);
   assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : 8'h00;
   assign bus.in_ready  = (state == COLLECT);
   assign pop           = bus.out_valid && bus.out_ready;
   assign push          = (state == PUSH) && (!full || pop);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= COLLECT;
         byte_cnt  <= 2'd0;
         word      <= 32'h0;
         sh_q      <= 5'd0;
         relu_q    <= 1'b0;
         q_value   <= 8'h00;
         sat_flag  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (bus.in_valid) begin
                  word <= {word[23:0], bus.in_byte};
                  if (bus.in_first || byte_cnt == 2'd0) begin
                     // Resync: a first-flagged byte mid-word restarts the word from here.
                     if (bus.in_first && byte_cnt != 2'd0) frame_err <= 1'b1;
                     sh_q     <= cfg_shift;
                     relu_q   <= cfg_relu;
                     byte_cnt <= 2'd1;
                  end else if (byte_cnt == 2'd3) begin
                     byte_cnt <= 2'd0;
                     state    <= QUANT;
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
            end
            QUANT: begin
               q_value <= sat_value;
               if (clip) sat_flag <= 1'b1;
               state <= PUSH;
            end
            PUSH: begin
               if (push) state <= COLLECT;
            end
            default: state <= COLLECT;
         endcase
      end
   end

   // NOTE: FIFO storage is not reset; fifo_count gates every read, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= q_value;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_result_quantizer.sv
// Directed self-checking bench for mac_result_quantizer; expected values follow the
// rounding mode selected by MACQ_ROUND_EN.
module tb_mac_result_quantizer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] cfg_shift = 5'd0;
   logic       cfg_relu = 1'b0;
   logic [2:0] fifo_count;
   logic       sat_flag;
   logic       frame_err;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef MACQ_ROUND_EN
   localparam logic [7:0] EXP_128 = 8'h13;
   localparam logic [7:0] EXP_M24 = 8'hFF;
`else
   localparam logic [7:0] EXP_128 = 8'h12;
   localparam logic [7:0] EXP_M24 = 8'hFE;
`endif

   mac_result_quantizer_if bus ();

   mac_result_quantizer #(.FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .cfg_shift  (cfg_shift),
      .cfg_relu   (cfg_relu),
      .fifo_count (fifo_count),
      .sat_flag   (sat_flag),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic first);
      int n = 0;
      @(negedge clk);
      bus.in_byte  = b;
      bus.in_valid = 1'b1;
      bus.in_first = first;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) check("in_ready_wait", bus.in_ready, 1'b1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
   endtask

   // Config is scrambled after byte 0 so the result also proves it was latched there.
   task automatic send_word(input logic [31:0] w, input logic [4:0] sh, input logic relu);
      cfg_shift = sh;
      cfg_relu  = relu;
      send_byte(w[31:24], 1'b1);
      cfg_shift = ~sh;
      cfg_relu  = ~relu;
      send_byte(w[23:16], 1'b0);
      send_byte(w[15:8],  1'b0);
      send_byte(w[7:0],   1'b0);
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] exp);
      int n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.out_valid) check({tag, "_valid"}, bus.out_valid, 1'b1);
      check(tag, bus.out_data, exp);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      bus.in_byte   = 8'h00;
      bus.in_valid  = 1'b0;
      bus.in_first  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",   bus.in_ready,  1'b1);
      check("rst_out_valid",  bus.out_valid, 1'b0);
      check("rst_out_data",   bus.out_data,  8'h00);
      check("rst_fifo_count", fifo_count,    3'd0);
      check("rst_sat",        sat_flag,      1'b0);
      check("rst_frame_err",  frame_err,     1'b0);
      rst_n = 1'b1;

      // Basic word with 3-cycle latency.
      send_word(32'h0000_0128, 5'd4, 1'b0);
      @(negedge clk);
      check("lat_quant_valid", bus.out_valid, 1'b0);
      check("lat_quant_ready", bus.in_ready,  1'b0);
      @(negedge clk);
      check("lat_push_valid",  bus.out_valid, 1'b0);
      @(negedge clk);
      check("lat_out_valid",   bus.out_valid, 1'b1);
      check("lat_in_ready",    bus.in_ready,  1'b1);
      pop_expect("w128_data", EXP_128);
      check("w128_sat", sat_flag, 1'b0);

      send_word(32'hFFFF_FFE8, 5'd4, 1'b0);
      pop_expect("m24_data", EXP_M24);
      check("m24_sat", sat_flag, 1'b0);

      send_word(32'hFFFF_FF00, 5'd0, 1'b1);
      pop_expect("m256_relu_data", 8'h00);
      check("m256_relu_sat", sat_flag, 1'b0);

      send_word(32'hFFFF_FF00, 5'd0, 1'b0);
      pop_expect("m256_data", 8'h80);
      check("m256_sat", sat_flag, 1'b1);

      // Resync on a first-flagged byte mid-word.
      cfg_shift = 5'd4;
      cfg_relu  = 1'b0;
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b0);
      check("frame_err_before", frame_err, 1'b0);
      send_word(32'h0000_0128, 5'd4, 1'b0);
      check("frame_err_set", frame_err, 1'b1);
      pop_expect("resync_data", EXP_128);
      repeat (3) @(negedge clk);
      check("resync_single", fifo_count, 3'd0);

      // Backpressure: four fill the FIFO, the fifth is held in PUSH.
      for (int k = 1; k <= 5; k++) send_word(32'h11 * k, 5'd0, 1'b0);
      repeat (4) @(negedge clk);
      check("bp_count",    fifo_count,   3'd4);
      check("bp_in_ready", bus.in_ready, 1'b0);
      for (int k = 1; k <= 5; k++) pop_expect($sformatf("bp_pop%0d", k), 8'(8'h11 * k));
      @(negedge clk);
      check("bp_drained",  fifo_count,   3'd0);
      check("bp_ready_back", bus.in_ready, 1'b1);

      // Reset mid-word with two entries queued.
      send_word(32'h0000_0030, 5'd0, 1'b0);
      send_word(32'h0000_0040, 5'd0, 1'b0);
      repeat (3) @(negedge clk);
      check("pre_rst_count", fifo_count, 3'd2);
      check("pre_rst_sat",   sat_flag,   1'b1);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_count",     fifo_count,    3'd0);
      check("mid_rst_out_valid", bus.out_valid, 1'b0);
      check("mid_rst_out_data",  bus.out_data,  8'h00);
      check("mid_rst_sat",       sat_flag,      1'b0);
      check("mid_rst_frame_err", frame_err,     1'b0);
      check("mid_rst_in_ready",  bus.in_ready,  1'b1);
      rst_n = 1'b1;
      send_word(32'h0000_0128, 5'd4, 1'b0);
      pop_expect("post_rst_data", EXP_128);
      repeat (3) @(negedge clk);
      check("post_rst_single", fifo_count, 3'd0);

      // Positive saturation.
      send_word(32'h0001_0000, 5'd4, 1'b0);
      pop_expect("pos_sat_data", 8'h7F);
      check("pos_sat_flag", sat_flag, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
